vga_pixel_timing: RTL



---
 rtl/vga_pixel_timing.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_timing.sv
// vga_pixel_timing
// Pixel-clock VGA output stage. Generates the raster (default 640x480@60),
// pulls one beat per active pixel from an upstream frame stream, locks that
// stream to the raster using sop/eop, and drives registered sync/blank/RGB.
//
// Ports
//   clk, rst_n                 pixel clock, async active-low reset
//   pll_locked                 PLL lock (async, synchronised here)
//   in_data/in_sop/in_eop      upstream pixel {R,G,B} and frame markers
//   in_valid/in_ready          upstream handshake
//   vga_hs/vga_vs              active-low syncs
//   vga_blank_n                high during active video
//   vga_r/vga_g/vga_b          colour, zero outside active video
//   err_clear                  clears sticky error flags
//   err_underflow/err_sync     sticky error flags
module vga_pixel_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_locked,
    input  logic [3*CW-1:0] in_data,
    input  logic            in_sop,
    input  logic            in_eop,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_blank_n,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b,
    input  logic            err_clear,
    output logic            err_underflow,
    output logic            err_sync
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, SEEK, ALIGN, RUN} state_t;

    state_t        state;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic [1:0]    lk_pipe;
    logic          lk;
    logic          h_last, v_last, active, at_first, at_last_px;
    logic          hs_on, vs_on, sync_bad;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lk_pipe <= '0;
        else        lk_pipe <= {lk_pipe[0], pll_locked};
    end
    assign lk = lk_pipe[1];

    always_comb begin
        h_last     = (hc == H_LAST);
        v_last     = (vc == V_LAST);
        active     = (hc < H_ACT) && (vc < V_ACT);
        at_first   = (hc == '0) && (vc == '0);
        at_last_px = (hc == H_ACT_LAST) && (vc == V_ACT_LAST);
        hs_on      = (hc >= HS_BEG) && (hc <= HS_END);
        vs_on      = (vc >= VS_BEG) && (vc <= VS_END);
        // sop only at the first pixel, eop exactly at the last one.
        sync_bad   = (in_sop && !at_first) || (in_eop != at_last_px);
        // Gated by lk so nothing is consumed in the cycle before the
        // unlocked reset takes effect.
        in_ready   = 1'b0;
        if (lk) begin
            case (state)
                SEEK:    in_ready = !in_sop;
                RUN:     in_ready = active;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hc            <= '0;
            vc            <= '0;
            vga_hs        <= 1'b1;
            vga_vs        <= 1'b1;
            vga_blank_n   <= 1'b0;
            {vga_r, vga_g, vga_b} <= '0;
            err_underflow <= 1'b0;
            err_sync      <= 1'b0;
        end else if (!lk) begin
            // Loss of lock looks exactly like reset from the pins.
            state         <= IDLE;
            hc            <= '0;
            vc            <= '0;
            vga_hs        <= 1'b1;
            vga_vs        <= 1'b1;
            vga_blank_n   <= 1'b0;
            {vga_r, vga_g, vga_b} <= '0;
            err_underflow <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            if (h_last) begin
                hc <= '0;
                vc <= v_last ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end

            // Raster pins always follow the counters, whatever the stream does.
            vga_hs      <= !hs_on;
            vga_vs      <= !vs_on;
            vga_blank_n <= active;
            {vga_r, vga_g, vga_b} <= '0;

            // Clear first so a same-cycle set below wins.
            if (err_clear) begin
                err_underflow <= 1'b0;
                err_sync      <= 1'b0;
            end

            case (state)
                IDLE:  state <= SEEK;
                SEEK:  if (in_valid && in_sop) state <= ALIGN;
                ALIGN: if (h_last && v_last) state <= RUN;
                RUN: begin
                    if (active) begin
                        if (!in_valid) begin
                            err_underflow <= 1'b1;
                            state         <= SEEK;
                        end else begin
                            {vga_r, vga_g, vga_b} <= in_data;
                            if (sync_bad) begin
                                err_sync <= 1'b1;
                                state    <= SEEK;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
